component_credit_fifo: RTL and testbench
========================================

Name: component_credit_fifo

Overview:
- Output buffer directly downstream of the fixed-latency register delay line. The delay line cannot stall, so this block absorbs everything it emits.
- Holds up to DEPTH entries and presents them to the consumer with a valid/ready handshake.
- Runs a credit counter that gates upstream issue into the delay line, so the FIFO never overflows regardless of consumer backpressure.

Parameters:
- WIDTH, 8, data width; matches the delay line's WIDTH.
- DEPTH, 8, FIFO entries; any value >= 2, not required to be a power of two.
- LATENCY, 4, delay-line cycle count; informational only, used by the bench to align in_valid with issue.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- issue_valid  input  1  upstream wants to launch one item into the delay line this cycle.
- issue_ready  output  1  a credit is available; an issue is accepted when issue_valid && issue_ready.
- in_valid  input  1  delay-line output carries a valid item this cycle.
- in_data  input  WIDTH  delay-line output data.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  WIDTH  head entry.
- count  output  $clog2(DEPTH+1)  entries currently stored.
- credits  output  $clog2(DEPTH+1)  free credits.
- overflow  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, ports clk and rst. The delay line shares the same rst.
- Reset values: count=0, credits=DEPTH, rd_ptr=wr_ptr=0, overflow=0, out_valid=0, out_data=0, issue_ready=1. Storage array is not reset.
- Credits:
  - issue_ready = (credits != 0), combinational.
  - Issue accepted: credits-1. Pop (out_valid && out_ready): credits+1. Both in one cycle: unchanged.
  - issue_valid while issue_ready=0 is ignored and consumes no credit.
  - Credits never exceed DEPTH and never go below 0.
- Push: on in_valid, write in_data to mem[wr_ptr]; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Pop: on out_valid && out_ready, rd_ptr advances with the same wrap. Pop while empty is ignored.
- count: +1 on push only, -1 on pop only, unchanged when both occur.
- Full with pop in the same cycle: push is accepted, count stays DEPTH.
- Full without pop: push is dropped, overflow sets to 1 and stays 1 until rst. Pointers and count are unchanged.
- Empty with push: entry becomes visible next cycle. No same-cycle bypass; minimum in_valid -> out_valid latency is 1 cycle.
- out_data = mem[rd_ptr] when out_valid=1, else 0. Combinational show-ahead read of registered storage.
- End-to-end: an issue accepted at cycle t reaches in_valid at t+LATENCY. With credits respected, overflow never asserts.
- Reset mid-operation: all state returns to reset values immediately, and in-flight delay-line items are cleared by the shared reset. Data presented on in_valid during rst=1 is ignored.

Test Plan:
1. Reset -> issue_ready=1, credits=8, count=0, out_valid=0, out_data=0, overflow=0.
2. Issue 8 items back-to-back, each returned on in_valid 4 cycles later (0x11..0x18), out_ready=0 -> credits 8->0, issue_ready=0 from the cycle after the 8th issue, count reaches 8, overflow=0.
3. From the full state, out_ready=1 for 8 cycles -> out_data 0x11..0x18 in order; credits climb back to 8; count=0; pointers have wrapped.
4. Steady stream: issue_valid=1 and out_ready=1 for 20 cycles -> after a 4+1 cycle fill, one pop per cycle, credits constant, 20 items out in order, overflow=0.
5. Fill to 8, then force in_valid=1 with data 0xAA and out_ready=0 -> 0xAA dropped, overflow=1 and held. Repeat with out_ready=1 in the same cycle -> accepted, count stays 8, no further flag change.
6. Assert rst with count=5, credits=1 -> all outputs at reset values the same cycle. After release, an item pushed with 0x3C appears as out_data=0x3C one cycle later.

Source files
------------

// File: rtl/component_credit_fifo.sv
// component_credit_fifo
//   Output buffer behind a fixed-latency delay line that cannot stall. Items
//   are stored in a circular buffer and handed to the consumer through a
//   valid/ready handshake. A credit counter gates upstream issue so that
//   every item launched into the delay line already has a slot reserved.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   issue_valid   upstream wants to launch an item this cycle
//   issue_ready   a credit is free; issue accepted on issue_valid && issue_ready
//   in_valid      delay-line output carries an item this cycle
//   in_data       delay-line output data
//   out_valid     buffer non-empty
//   out_ready     consumer takes the head entry
//   out_data      head entry (zero while empty)
//   count         entries stored
//   credits       free credits
//   overflow      sticky: an item arrived while full with no pop
module component_credit_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // LATENCY only describes the upstream delay line; it is checked here so
    // a nonsensical configuration fails at elaboration.
    if (DEPTH < 2 || LATENCY < 1) begin : g_bad_param
        $error("component_credit_fifo: DEPTH must be >= 2 and LATENCY >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             pop;
    logic             push;
    logic             issue_acc;
    logic [CW-1:0]    credits_next;

    assign full        = (count == CW'(DEPTH));
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    // A full buffer can still take an item when the head leaves this cycle.
    assign push        = in_valid && (!full || pop);
    assign issue_ready = (credits != '0);
    assign issue_acc   = issue_valid && issue_ready;
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    // Saturating at DEPTH matters only when items arrive without a credit
    // (overflow condition); normal flow never reaches the bound.
    always_comb begin
        credits_next = credits;
        if (issue_acc && !pop) begin
            credits_next = credits - 1'b1;
        end else if (pop && !issue_acc && credits != CW'(DEPTH)) begin
            credits_next = credits + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            credits  <= CW'(DEPTH);
            overflow <= 1'b0;
        end else begin
            credits <= credits_next;
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_component_credit_fifo.sv
module tb_component_credit_fifo;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int LATENCY = 4;
    localparam int CW      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic [CW-1:0]    credits;
    logic             overflow;

    // Delay-line stand-in plus a direct injection path for error cases.
    logic             dl_v [LATENCY];
    logic [WIDTH-1:0] dl_d [LATENCY];
    logic             force_v = 1'b0;
    logic [WIDTH-1:0] force_d = '0;
    logic [WIDTH-1:0] next_data = 8'h11;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    assign in_valid = dl_v[LATENCY-1] | force_v;
    assign in_data  = force_v ? force_d : dl_d[LATENCY-1];

    component_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .credits(credits), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_v[i] <= 1'b0;
                dl_d[i] <= '0;
            end
            next_data <= 8'h11;
        end else begin
            dl_v[0] <= issue_valid && issue_ready;
            dl_d[0] <= next_data;
            if (issue_valid && issue_ready) next_data <= next_data + 8'd1;
            for (int i = 1; i < LATENCY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_d[i] <= dl_d[i-1];
            end
        end
    end

    // Reference model: a queue of stored items, an integer credit pool and
    // a sticky flag, updated from the handshake rules.
    logic [WIDTH-1:0] q [$];
    int               m_cred = DEPTH;
    bit               m_ovf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cred = DEPTH;
            m_ovf  = 1'b0;
        end else begin
            bit m_pop, m_iss;
            m_pop = (q.size() != 0) && out_ready;
            m_iss = issue_valid && (m_cred > 0);
            if (m_pop) void'(q.pop_front());
            if (in_valid) begin
                if (q.size() < DEPTH) q.push_back(in_data);
                else m_ovf = 1'b1;
            end
            m_cred = m_cred - int'(m_iss) + int'(m_pop);
            if (m_cred > DEPTH) m_cred = DEPTH;
            if (m_cred < 0) m_cred = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_count",       int'(count),       q.size());
            chk("m_credits",     int'(credits),     m_cred);
            chk("m_issue_ready", int'(issue_ready), int'(m_cred != 0));
            chk("m_out_valid",   int'(out_valid),   int'(q.size() != 0));
            chk("m_out_data",    int'(out_data),    (q.size() != 0) ? int'(q[0]) : 0);
            chk("m_overflow",    int'(overflow),    int'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_d;
        int popped;

        // 1. reset values
        step();
        step();
        rst = 1'b0;
        run_cmp = 1'b1;
        chk("rst_issue_ready", int'(issue_ready), 1);
        chk("rst_credits",     int'(credits),     8);
        chk("rst_count",       int'(count),       0);
        chk("rst_out_valid",   int'(out_valid),   0);
        chk("rst_out_data",    int'(out_data),    0);
        chk("rst_overflow",    int'(overflow),    0);

        // 2. issue 8 back-to-back, consumer stalled; extra issues are ignored
        issue_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("fill_credits", int'(credits), (i <= 8) ? 8 - i : 0);
            chk("fill_issue_ready", int'(issue_ready), (i < 8) ? 1 : 0);
        end
        issue_valid = 1'b0;
        repeat (4) step();
        chk("fill_count",    int'(count),    8);
        chk("fill_overflow", int'(overflow), 0);

        // 3. drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", int'(out_data), 8'h11 + i);
            step();
        end
        out_ready = 1'b0;
        chk("drain_count",   int'(count),     0);
        chk("drain_credits", int'(credits),   8);
        chk("drain_valid",   int'(out_valid), 0);

        // 4. steady stream of 20 items
        exp_d  = 8'h19;
        popped = 0;
        issue_valid = 1'b1;
        out_ready   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) issue_valid = 1'b0;
            if (out_valid) begin
                chk("stream_data", int'(out_data), exp_d);
                exp_d++;
                popped++;
            end
            step();
        end
        out_ready = 1'b0;
        chk("stream_popped",   popped,          20);
        chk("stream_overflow", int'(overflow),  0);
        chk("stream_credits",  int'(credits),   8);

        // 5. overflow: drop while full, then accept with simultaneous pop
        issue_valid = 1'b1;
        repeat (10) step();
        issue_valid = 1'b0;
        repeat (4) step();
        chk("ovf_fill_count", int'(count), 8);
        force_v = 1'b1;
        force_d = 8'hAA;
        step();
        force_v = 1'b0;
        chk("ovf_flag",  int'(overflow), 1);
        chk("ovf_count", int'(count),    8);
        chk("ovf_head",  int'(out_data), 8'h2D);
        step();
        chk("ovf_sticky", int'(overflow), 1);
        force_v   = 1'b1;
        out_ready = 1'b1;
        step();
        force_v   = 1'b0;
        out_ready = 1'b0;
        chk("pp_count",    int'(count),    8);
        chk("pp_overflow", int'(overflow), 1);
        chk("pp_credits",  int'(credits),  1);
        chk("pp_head",     int'(out_data), 8'h2E);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", int'(out_data), (i == 7) ? 8'hAA : 8'h2E + i);
            step();
        end
        out_ready = 1'b0;
        chk("pp_end_credits", int'(credits), 8);

        // 6. reset mid-operation with count=5, credits=1
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        issue_valid = 1'b1;
        repeat (7) step();
        issue_valid = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (2) step();
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        repeat (2) step();
        issue_valid = 1'b0;
        chk("pre_rst_count",   int'(count),   5);
        chk("pre_rst_credits", int'(credits), 1);
        rst     = 1'b1;
        force_v = 1'b1;
        force_d = 8'h77;
        #1;
        chk("mid_rst_issue_ready", int'(issue_ready), 1);
        chk("mid_rst_credits",     int'(credits),     8);
        chk("mid_rst_count",       int'(count),       0);
        chk("mid_rst_out_valid",   int'(out_valid),   0);
        chk("mid_rst_out_data",    int'(out_data),    0);
        chk("mid_rst_overflow",    int'(overflow),    0);
        step();
        rst     = 1'b0;
        force_v = 1'b0;
        repeat (6) step();
        chk("post_rst_count", int'(count), 0);
        force_v = 1'b1;
        force_d = 8'h3C;
        chk("no_bypass", int'(out_valid), 0);
        step();
        force_v = 1'b0;
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data",  int'(out_data),  8'h3C);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
